// File: rtl/tppe_mt.sv
// Multi-timestep temporal-parallel PE: intersects spike and weight bitmasks over
// one or more chunks, fetches matched spike vectors and accumulates saturating sums.
module tppe_mt #(
    parameter int BITMASK_WIDTH = 16,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int TIMESTEPS     = 4,
    parameter int ACC_WIDTH     = 12,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [BITMASK_WIDTH-1:0]            bitmask_a,
    input  logic [BITMASK_WIDTH-1:0]            bitmask_b,
    input  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] weights,
    input  logic [ADDR_WIDTH-1:0]               fibre_a_base,
    input  logic                                in_last,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                rd_req,
    output logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic                                rd_valid,
    input  logic [TIMESTEPS-1:0]                rd_data,
    output logic [TIMESTEPS*ACC_WIDTH-1:0]      results,
    output logic                                result_valid,
    input  logic                                result_ready
);

    localparam int IDX_W = (BITMASK_WIDTH > 1) ? $clog2(BITMASK_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REQ,
        OUT
    } state_t;

    state_t                            state;
    logic [BITMASK_WIDTH-1:0]          a_q;
    logic [BITMASK_WIDTH-1:0]          b_q;
    logic [BITMASK_WIDTH-1:0]          match_q;
    logic [BITMASK_WIDTH-1:0]          pick_q;
    logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] weights_q;
    logic [ADDR_WIDTH-1:0]             base_q;
    logic                              last_q;
    logic [IDX_W-1:0]                  widx_q;
    logic signed [ACC_WIDTH-1:0]       acc [TIMESTEPS];

    logic signed [WEIGHT_WIDTH-1:0]    weight_arr [BITMASK_WIDTH];
    logic [BITMASK_WIDTH-1:0]          lowest;
    logic [BITMASK_WIDTH-1:0]          below;
    int unsigned                       pc_a;
    int unsigned                       pc_b;

    function automatic int unsigned popcount(input logic [BITMASK_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < BITMASK_WIDTH; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

    // The sum is formed one bit wider than the accumulator so overflow shows up
    // as a disagreement between the two top bits.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0]    a,
        input logic signed [WEIGHT_WIDTH-1:0] w
    );
        logic signed [ACC_WIDTH:0] sum;
        sum = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return sum[ACC_WIDTH-1:0];
    endfunction

    for (genvar j = 0; j < BITMASK_WIDTH; j++) begin : g_weights
        assign weight_arr[j] = weights_q[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    for (genvar t = 0; t < TIMESTEPS; t++) begin : g_results
        assign results[t*ACC_WIDTH +: ACC_WIDTH] = acc[t];
    end

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        lowest = match_q & (~match_q + BITMASK_WIDTH'(1));
        below  = lowest - BITMASK_WIDTH'(1);
        pc_a   = popcount(a_q & below);
        pc_b   = popcount(b_q & below);
    end

    // NOTE: state is updated with non-blocking assignments only, so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            rd_req       <= 1'b0;
            rd_addr      <= '0;
            result_valid <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            match_q      <= '0;
            pick_q       <= '0;
            weights_q    <= '0;
            base_q       <= '0;
            last_q       <= 1'b0;
            widx_q       <= '0;
            // NOTE: the accumulator array is reset because results must read 0 out of reset.
            for (int t = 0; t < TIMESTEPS; t++) begin
                acc[t] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q       <= bitmask_a;
                        b_q       <= bitmask_b;
                        match_q   <= bitmask_a & bitmask_b;
                        weights_q <= weights;
                        base_q    <= fibre_a_base;
                        last_q    <= in_last;
                        in_ready  <= 1'b0;
                        state     <= SCAN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (match_q == '0) begin
                        if (last_q) begin
                            result_valid <= 1'b1;
                            state        <= OUT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        rd_addr <= base_q + ADDR_WIDTH'(pc_a);
                        widx_q  <= IDX_W'(pc_b);
                        pick_q  <= lowest;
                        rd_req  <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (rd_valid) begin
                        for (int t = 0; t < TIMESTEPS; t++) begin
                            if (rd_data[t]) begin
                                acc[t] <= sat_add(acc[t], weight_arr[widx_q]);
                            end
                        end
                        match_q <= match_q & ~pick_q;
                        rd_req  <= 1'b0;
                        state   <= SCAN;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        for (int t = 0; t < TIMESTEPS; t++) begin
                            acc[t] <= '0;
                        end
                        result_valid <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tppe_mt.sv
// Self-checking bench for tppe_mt: directed scenarios plus randomized chunks
// compared against a position-by-position arithmetic model.
module tb_tppe_mt;

    localparam int BW  = 16;
    localparam int WW  = 8;
    localparam int TS  = 4;
    localparam int ACW = 12;
    localparam int AW  = 8;
    localparam int AMAX = 2 ** (ACW - 1) - 1;
    localparam int AMIN = -(2 ** (ACW - 1));

    logic              clk;
    logic              rst_n;
    logic [BW-1:0]     bitmask_a;
    logic [BW-1:0]     bitmask_b;
    logic [BW*WW-1:0]  weights;
    logic [AW-1:0]     fibre_a_base;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic [TS-1:0]     rd_data;
    logic [TS*ACW-1:0] results;
    logic              result_valid;
    logic              result_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [TS-1:0] mem [256];
    int            w_arr [BW];
    int            exp_acc [TS];

    tppe_mt #(
        .BITMASK_WIDTH(BW),
        .WEIGHT_WIDTH (WW),
        .TIMESTEPS    (TS),
        .ACC_WIDTH    (ACW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bitmask_a    (bitmask_a),
        .bitmask_b    (bitmask_b),
        .weights      (weights),
        .fibre_a_base (fibre_a_base),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .results      (results),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int res(input int t);
        logic signed [ACW-1:0] v;
        v = results[t*ACW +: ACW];
        return int'(v);
    endfunction

    function automatic int clamp(input int v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    task automatic pack_weights();
        logic [31:0] w;
        for (int j = 0; j < BW; j++) begin
            w = w_arr[j];
            weights[j*WW +: WW] = w[WW-1:0];
        end
    endtask

    // Presents one chunk, serves its reads with the given latency, and updates the
    // model. Returns the cycle (1 = first negedge after accept) result_valid rose.
    task automatic send_chunk(input logic [BW-1:0] a, input logic [BW-1:0] b,
                              input logic [AW-1:0] base, input logic last,
                              input int lat, output int rv_cycle);
        int  exp_q[$];
        int  obs_q[$];
        int  cyc;
        int  cnt;
        int  cur;
        int  pa;
        int  pb;
        int  addr;
        bit  active;
        bit  done;
        logic [TS-1:0] vec;

        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        else pass_cnt++;

        for (int k = 0; k < BW; k++) begin
            if (a[k] && b[k]) begin
                pa = 0;
                pb = 0;
                for (int i = 0; i < k; i++) begin
                    pa += int'(a[i]);
                    pb += int'(b[i]);
                end
                addr = (int'(base) + pa) % 256;
                exp_q.push_back(addr);
                vec = mem[addr];
                for (int t = 0; t < TS; t++) begin
                    if (vec[t]) exp_acc[t] = clamp(exp_acc[t] + w_arr[pb]);
                end
            end
        end

        bitmask_a    = a;
        bitmask_b    = b;
        fibre_a_base = base;
        in_last      = last;
        pack_weights();
        in_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid     = 1'b0;
        bitmask_a    = BW'($urandom);
        bitmask_b    = BW'($urandom);
        fibre_a_base = AW'($urandom);
        in_last      = 1'($urandom);
        weights      = {4{$urandom}};

        cyc      = 0;
        done     = 0;
        active   = 0;
        cnt      = 0;
        cur      = 0;
        rv_cycle = -1;
        while (!done && cyc < 600) begin
            cyc++;
            if (result_valid === 1'b1 && rv_cycle < 0) rv_cycle = cyc;
            if (last ? (result_valid === 1'b1) : (in_ready === 1'b1)) done = 1;
            rd_valid = 1'b0;
            rd_data  = TS'($urandom);
            if (rd_req === 1'b1) begin
                if (!active) begin
                    active = 1;
                    cnt    = lat;
                    cur    = int'(rd_addr);
                    obs_q.push_back(int'(rd_addr));
                end else begin
                    total_cnt++;
                    if (int'(rd_addr) !== cur)
                        $display("FAIL rd_addr_stable: got %0d required %0d", rd_addr, cur);
                    else pass_cnt++;
                end
                if (cnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = mem[rd_addr];
                    active   = 0;
                end else begin
                    cnt--;
                end
            end
            if (!done) @(negedge clk);
        end
        rd_valid = 1'b0;

        total_cnt++;
        if (!done) $display("FAIL chunk_timeout: done=%0d required 1", done);
        else pass_cnt++;

        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL read_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL read_addr_%0d: got %0d required %0d", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic take_result();
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        for (int t = 0; t < TS; t++) exp_acc[t] = 0;
    endtask

    task automatic set_test1_data();
        for (int j = 0; j < BW; j++) w_arr[j] = 0;
        w_arr[0] = 3;
        w_arr[1] = 5;
        for (int i = 0; i < 256; i++) mem[i] = 4'b0000;
        mem[0] = 4'b1010;
        mem[2] = 4'b1111;
    endtask

    task automatic test_reset();
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        bitmask_a    = '0;
        bitmask_b    = '0;
        weights      = '0;
        fibre_a_base = '0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        result_ready = 1'b0;
        for (int t = 0; t < TS; t++) exp_acc[t] = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({in_ready, rd_req, result_valid} !== 3'b000)
            $display("FAIL reset_ctrl: got %b required 000", {in_ready, rd_req, result_valid});
        else pass_cnt++;
        total_cnt++;
        if (rd_addr !== '0) $display("FAIL reset_addr: got %0d required 0", rd_addr);
        else pass_cnt++;
        total_cnt++;
        if (results !== '0) $display("FAIL reset_results: got %h required 0", results);
        else pass_cnt++;
        rst_n = 1'b1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL ready_at_release: got %b required 0", in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_release: got %b required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_latency_sweep();
        int lats[3] = '{0, 1, 7};
        int rv;
        int fixed_exp[TS] = '{5, 8, 5, 8};
        set_test1_data();
        foreach (lats[i]) begin
            send_chunk(16'h002C, 16'h0024, 8'd0, 1'b1, lats[i], rv);
            for (int t = 0; t < TS; t++) begin
                total_cnt++;
                if (res(t) !== fixed_exp[t] || exp_acc[t] !== fixed_exp[t])
                    $display("FAIL two_match_lat%0d_t%0d: got %0d required %0d", lats[i], t, res(t), fixed_exp[t]);
                else pass_cnt++;
            end
            take_result();
        end
    endtask

    task automatic test_pos_saturation();
        int rv;
        for (int j = 0; j < BW; j++) w_arr[j] = 127;
        for (int i = 0; i < 256; i++) mem[i] = 4'b0001;
        send_chunk(16'hFFFF, 16'hFFFF, 8'd10, 1'b0, 0, rv);
        total_cnt++;
        if (rv != -1) $display("FAIL pos_sat_early_valid: got cycle %0d required none", rv);
        else pass_cnt++;
        send_chunk(16'hFFFF, 16'hFFFF, 8'd250, 1'b1, 1, rv);
        for (int t = 0; t < TS; t++) begin
            total_cnt++;
            if (res(t) !== (t == 0 ? 2047 : 0))
                $display("FAIL pos_sat_t%0d: got %0d required %0d", t, res(t), (t == 0 ? 2047 : 0));
            else pass_cnt++;
        end
        take_result();
    endtask

    task automatic test_neg_saturation();
        int rv;
        for (int j = 0; j < BW; j++) w_arr[j] = -128;
        for (int i = 0; i < 256; i++) mem[i] = 4'b0001;
        send_chunk(16'hFFFF, 16'hFFFF, 8'd0, 1'b0, 0, rv);
        send_chunk(16'hFFFF, 16'hFFFF, 8'd100, 1'b1, 0, rv);
        total_cnt++;
        if (res(0) !== -2048) $display("FAIL neg_sat_t0: got %0d required -2048", res(0));
        else pass_cnt++;
        take_result();
    endtask

    task automatic test_empty();
        int rv;
        send_chunk(16'h00F0, 16'h000F, 8'd5, 1'b1, 0, rv);
        total_cnt++;
        if (rv != 2) $display("FAIL empty_valid_cycle: got %0d required 2", rv);
        else pass_cnt++;
        total_cnt++;
        if (results !== '0) $display("FAIL empty_results: got %h required 0", results);
        else pass_cnt++;
        take_result();
    endtask

    task automatic test_back_pressure();
        int rv;
        set_test1_data();
        send_chunk(16'h002C, 16'h0024, 8'd0, 1'b1, 2, rv);
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            bitmask_a = 16'hFFFF;
            bitmask_b = 16'hFFFF;
            in_last   = 1'b1;
            @(negedge clk);
            total_cnt++;
            if ({result_valid, in_ready} !== 2'b10)
                $display("FAIL bp_ctrl_c%0d: got %b required 10", c, {result_valid, in_ready});
            else pass_cnt++;
            for (int t = 0; t < TS; t++) begin
                total_cnt++;
                if (res(t) !== exp_acc[t])
                    $display("FAIL bp_hold_c%0d_t%0d: got %0d required %0d", c, t, res(t), exp_acc[t]);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        take_result();
        total_cnt++;
        if (results !== '0 || result_valid !== 1'b0)
            $display("FAIL bp_clear: got %h/%b required 0/0", results, result_valid);
        else pass_cnt++;
        send_chunk(16'h002C, 16'h0024, 8'd0, 1'b1, 0, rv);
        for (int t = 0; t < TS; t++) begin
            total_cnt++;
            if (res(t) !== exp_acc[t])
                $display("FAIL bp_next_t%0d: got %0d required %0d", t, res(t), exp_acc[t]);
            else pass_cnt++;
        end
        take_result();
    endtask

    task automatic test_reset_mid_read();
        int  cyc;
        int  rv;
        set_test1_data();
        bitmask_a    = 16'h002C;
        bitmask_b    = 16'h0024;
        fibre_a_base = 8'd0;
        in_last      = 1'b1;
        pack_weights();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (rd_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        rd_valid = 1'b1;
        rd_data  = mem[rd_addr];
        @(posedge clk);
        @(negedge clk);
        rd_valid = 1'b0;
        total_cnt++;
        if (res(1) !== 3) $display("FAIL partial_sum_t1: got %0d required 3", res(1));
        else pass_cnt++;
        cyc = 0;
        while (rd_req !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        total_cnt++;
        if (rd_req !== 1'b1) $display("FAIL second_req: got %b required 1", rd_req);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({rd_req, result_valid, in_ready} !== 3'b000)
            $display("FAIL async_reset_ctrl: got %b required 000", {rd_req, result_valid, in_ready});
        else pass_cnt++;
        total_cnt++;
        if (results !== '0) $display("FAIL async_reset_results: got %h required 0", results);
        else pass_cnt++;
        for (int t = 0; t < TS; t++) exp_acc[t] = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 4'hF;
        repeat (3) @(negedge clk);
        rd_valid = 1'b0;
        total_cnt++;
        if ({results, rd_req, in_ready} !== {{(TS*ACW){1'b0}}, 2'b01})
            $display("FAIL stale_response: got %h/%b/%b required 0/0/1", results, rd_req, in_ready);
        else pass_cnt++;
        send_chunk(16'h002C, 16'h0024, 8'd0, 1'b1, 3, rv);
        for (int t = 0; t < TS; t++) begin
            total_cnt++;
            if (res(t) !== ((t % 2 == 1) ? 8 : 5))
                $display("FAIL after_reset_t%0d: got %0d required %0d", t, res(t), ((t % 2 == 1) ? 8 : 5));
            else pass_cnt++;
        end
        take_result();
    endtask

    task automatic test_random();
        int rv;
        logic last;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        for (int i = 0; i < 256; i++) mem[i] = TS'($urandom);
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < BW; j++) w_arr[j] = int'($urandom_range(0, 255)) - 128;
            a    = BW'($urandom) | BW'($urandom);
            b    = BW'($urandom);
            last = ($urandom_range(0, 2) == 0) || (n == 15);
            send_chunk(a, b, AW'($urandom), last, int'($urandom_range(0, 3)), rv);
            if (last) begin
                for (int t = 0; t < TS; t++) begin
                    total_cnt++;
                    if (res(t) !== exp_acc[t])
                        $display("FAIL random_n%0d_t%0d: got %0d required %0d", n, t, res(t), exp_acc[t]);
                    else pass_cnt++;
                end
                take_result();
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency_sweep();
        test_pos_saturation();
        test_neg_saturation();
        test_empty();
        test_back_pressure();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
